// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: shared definitions for the immediate encoder.
//   - EXT_CTRL_* format codes (same encoding the immediate extender decodes)
//   - opcodes used by the li expansion
//   - output-register state type
//   - signed range helper used by the field placer
package imm_encoder_pkg;

  localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b000001;
  localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b000010;
  localparam logic [5:0] EXT_CTRL_STYPE       = 6'b000100;
  localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b001000;
  localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b010000;
  localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b100000;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_LI_HI = 2'd2
  } enc_state_e;

  // True when v, read as a signed 32-bit value, lies in [lo, hi].
  function automatic logic in_srange(input logic [31:0] v,
                                     input logic signed [31:0] lo,
                                     input logic signed [31:0] hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/imm_encoder_imm_place.sv
// imm_place: combinational field placer, the inverse of the immediate
// extender. Writes imm into the scattered bit positions of the selected
// format and flags immediates that do not fit (the truncated word is still
// produced).
//   fmt_i  : EXT_CTRL_* format code
//   base_i : instruction word supplying all non-immediate fields
//   imm_i  : immediate as a full signed value / byte offset
//   word_o : base_i with the immediate fields overwritten
//   err_o  : immediate out of range or unknown format
module imm_place
  import imm_encoder_pkg::*;
(
  input  logic [5:0]  fmt_i,
  input  logic [31:0] base_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  // Field placement and range check per format.
  always_comb begin
    word_o = base_i;
    err_o  = 1'b0;
    case (fmt_i)
      EXT_CTRL_ITYPE_SHAMT: begin
        word_o[24:20] = imm_i[4:0];
        err_o         = (imm_i[31:5] != 27'd0);
      end
      EXT_CTRL_ITYPE: begin
        word_o[31:20] = imm_i[11:0];
        err_o         = !in_srange(imm_i, -32'sd2048, 32'sd2047);
      end
      EXT_CTRL_STYPE: begin
        word_o[31:25] = imm_i[11:5];
        word_o[11:7]  = imm_i[4:0];
        err_o         = !in_srange(imm_i, -32'sd2048, 32'sd2047);
      end
      EXT_CTRL_BTYPE: begin
        word_o[31]    = imm_i[12];
        word_o[30:25] = imm_i[10:5];
        word_o[11:8]  = imm_i[4:1];
        word_o[7]     = imm_i[11];
        err_o         = !in_srange(imm_i, -32'sd4096, 32'sd4094) || imm_i[0];
      end
      EXT_CTRL_UTYPE: begin
        word_o[31:12] = imm_i[31:12];
        err_o         = (imm_i[11:0] != 12'd0);
      end
      EXT_CTRL_JTYPE: begin
        word_o[31]    = imm_i[20];
        word_o[30:21] = imm_i[10:1];
        word_o[20]    = imm_i[11];
        word_o[19:12] = imm_i[19:12];
        err_o         = !in_srange(imm_i, -32'sd1048576, 32'sd1048574) || imm_i[0];
      end
      default: begin
        word_o = base_i;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: immediate encoder with valid/ready streams on both sides.
// Encodes one instruction per request, or expands li into LUI+ADDI.
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready       : request handshake
//   in_fmt, in_li           : format code / li expansion select
//   in_base, in_imm         : base word (rd only for li) and immediate
//   out_valid/out_ready     : output handshake
//   out_data/out_err/out_last : encoded word, range error, last word of request
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_fmt,
  input  logic        in_li,
  input  logic [31:0] in_base,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        out_last
);

  enc_state_e  state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] place_word;
  logic        place_err;
  logic        accept;
  logic [31:0] hi_sum;
  logic [4:0]  li_rd;
  logic [31:0] li_lui;
  logic [31:0] li_addi;

  imm_place u_place (
    .fmt_i  (in_fmt),
    .base_i (in_base),
    .imm_i  (in_imm),
    .word_o (place_word),
    .err_o  (place_err)
  );

  assign in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign out_last  = last_q;

  // li split: adding 0x800 before taking the upper bits compensates for the
  // sign extension ADDI applies to lo.
  assign hi_sum  = in_imm + 32'h0000_0800;
  assign li_rd   = in_base[11:7];
  assign li_lui  = {hi_sum[31:12], li_rd, OPC_LUI};
  // With hi == 0 the ADDI sources x0 so it stands alone.
  assign li_addi = {in_imm[11:0], ((hi_sum[31:12] != 20'd0) ? li_rd : 5'd0),
                    3'b000, li_rd, OPC_OPIMM};

  // Next-state and output-register load logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    last_d  = last_q;
    pend_d  = pend_q;
    if (accept) begin
      if (in_li) begin
        err_d = 1'b0;
        if (hi_sum[31:12] != 20'd0) begin
          state_d = ST_LI_HI;
          data_d  = li_lui;
          last_d  = 1'b0;
          pend_d  = li_addi;
        end else begin
          state_d = ST_FULL;
          data_d  = li_addi;
          last_d  = 1'b1;
        end
      end else begin
        state_d = ST_FULL;
        data_d  = place_word;
        err_d   = place_err;
        last_d  = 1'b1;
      end
    end else if (out_valid && out_ready) begin
      if (state_q == ST_LI_HI) begin
        state_d = ST_FULL;
        data_d  = pend_q;
        err_d   = 1'b0;
        last_d  = 1'b1;
        pend_d  = 32'd0;
      end else begin
        state_d = ST_EMPTY;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, output and pending-ADDI registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed self-checking bench for imm_encoder.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_fmt;
  logic        in_li;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        out_last;

  int n_checks = 0;
  int n_errors = 0;

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_li     (in_li),
    .in_base   (in_base),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request (called #1 after an edge) and hold it until accepted.
  task automatic do_req(input logic li, input logic [5:0] fmt,
                        input logic [31:0] base, input logic [31:0] imm);
    int waited;
    in_valid = 1'b1;
    in_li    = li;
    in_fmt   = fmt;
    in_base  = base;
    in_imm   = imm;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check_eq("req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Check the held word, then pop it with a one-cycle out_ready pulse.
  task automatic pop_word(input string tag, input logic [31:0] data,
                          input logic err, input logic last);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_data"},  out_data, data);
    check_eq({tag, "_err"},   {31'd0, out_err}, {31'd0, err});
    check_eq({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_li = 1'b0; in_fmt = 6'd0;
    in_base = 32'd0; in_imm = 32'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_data",  out_data, 32'd0);
    check_eq("rst_err",   {31'd0, out_err}, 32'd0);
    check_eq("rst_last",  {31'd0, out_last}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_valid2", {31'd0, out_valid}, 32'd0);

    // Single-format encodes, including range boundaries.
    do_req(1'b0, EXT_CTRL_ITYPE, 32'h0000_0013, 32'hFFFF_FFFF);
    pop_word("i_m1", 32'hFFF0_0013, 1'b0, 1'b1);
    check_eq("i_m1_empty", {31'd0, out_valid}, 32'd0);
    do_req(1'b0, EXT_CTRL_BTYPE, 32'h0000_0063, 32'hFFFF_FFFC);
    pop_word("b_m4", 32'hFE00_0EE3, 1'b0, 1'b1);
    do_req(1'b0, EXT_CTRL_STYPE, 32'h0000_0023, 32'd2048);
    pop_word("s_2048", 32'h8000_0023, 1'b1, 1'b1);
    do_req(1'b0, EXT_CTRL_BTYPE, 32'h0000_0063, 32'd3);
    pop_word("b_3", 32'h0000_0163, 1'b1, 1'b1);
    do_req(1'b0, EXT_CTRL_BTYPE, 32'h0000_0063, 32'd4094);
    pop_word("b_4094", 32'h7E00_0FE3, 1'b0, 1'b1);
    do_req(1'b0, EXT_CTRL_ITYPE_SHAMT, 32'h0000_1013, 32'd32);
    pop_word("sh_32", 32'h0000_1013, 1'b1, 1'b1);
    do_req(1'b0, EXT_CTRL_ITYPE_SHAMT, 32'h0000_1013, 32'd31);
    pop_word("sh_31", 32'h01F0_1013, 1'b0, 1'b1);
    do_req(1'b0, EXT_CTRL_ITYPE, 32'h0000_0013, 32'd2047);
    pop_word("i_2047", 32'h7FF0_0013, 1'b0, 1'b1);
    do_req(1'b0, EXT_CTRL_ITYPE, 32'h0000_0013, 32'hFFFF_F7FF);
    pop_word("i_m2049", 32'h7FF0_0013, 1'b1, 1'b1);
    do_req(1'b0, EXT_CTRL_UTYPE, 32'h0000_0037, 32'h1234_5000);
    pop_word("u_ok", 32'h1234_5037, 1'b0, 1'b1);
    do_req(1'b0, EXT_CTRL_UTYPE, 32'h0000_0037, 32'h1234_5001);
    pop_word("u_bad", 32'h1234_5037, 1'b1, 1'b1);
    do_req(1'b0, EXT_CTRL_JTYPE, 32'h0000_006F, 32'd2048);
    pop_word("j_2048", 32'h0010_006F, 1'b0, 1'b1);
    do_req(1'b0, EXT_CTRL_JTYPE, 32'h0000_006F, 32'hFFF0_0000);
    pop_word("j_min", 32'h8000_006F, 1'b0, 1'b1);
    do_req(1'b0, EXT_CTRL_JTYPE, 32'h0000_006F, 32'h0010_0000);
    pop_word("j_over", 32'h8000_006F, 1'b1, 1'b1);
    do_req(1'b0, 6'b000000, 32'hDEAD_BEEF, 32'h0000_0123);
    pop_word("unk_fmt", 32'hDEAD_BEEF, 1'b1, 1'b1);

    // li expansions.
    do_req(1'b1, 6'd0, 32'h0000_0280, 32'h1234_5FFF);
    check_eq("li_hi_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("li_hold_data", out_data, 32'h1234_62B7);
      check_eq("li_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    pop_word("li_lui", 32'h1234_62B7, 1'b0, 1'b0);
    pop_word("li_addi", 32'hFFF2_8293, 1'b0, 1'b1);
    check_eq("li_done", {31'd0, out_valid}, 32'd0);
    do_req(1'b1, EXT_CTRL_UTYPE, 32'h0000_0280, 32'd5);
    pop_word("li_small", 32'h0050_0293, 1'b0, 1'b1);
    do_req(1'b1, 6'd0, 32'h0000_0280, 32'hFFFF_F800);
    pop_word("li_m2048", 32'h8000_0293, 1'b0, 1'b1);

    // Back-to-back I requests drain at one word per cycle.
    out_ready = 1'b1;
    in_valid = 1'b1; in_li = 1'b0; in_fmt = EXT_CTRL_ITYPE;
    in_base = 32'h0000_0013; in_imm = 32'd1;
    @(posedge clk); #1;
    check_eq("b2b_w1", out_data, 32'h0010_0013);
    check_eq("b2b_rdy1", {31'd0, in_ready}, 32'd1);
    in_imm = 32'd2;
    @(posedge clk); #1;
    check_eq("b2b_w2", out_data, 32'h0020_0013);
    check_eq("b2b_v2", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("b2b_drain", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Reset while holding the LUI drops the whole pair.
    do_req(1'b1, 6'd0, 32'h0000_0280, 32'h1234_5FFF);
    check_eq("rli_last", {31'd0, out_last}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rli_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rli_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rli_no_addi", {31'd0, out_valid}, 32'd0);
    end
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
